// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix result arbiter slice.
//   state_t     : arbiter control states
//   MAXW_DEF    : default coordinate width
//   NCORES_DEF  : default number of requesting cores
//   ADDR_W      : result RAM address width for the default coordinate width
//   CNT_W       : write counter width, wide enough for (2^MAXW)^2 cells
package matrix_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int MAXW_DEF   = 4;
  localparam int NCORES_DEF = 5;
  localparam int ADDR_W     = 2*MAXW_DEF;
  localparam int CNT_W      = 2*MAXW_DEF + 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Selects the first asserted request at or after i_ptr, wrapping modulo N.
//   i_req : request vector, one bit per requester
//   i_ptr : index with highest priority this cycle
//   o_gnt : one-hot grant (zero when no request)
//   o_idx : index of the granted requester
//   o_any : at least one request present
module rr_picker #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    logic [PW-1:0] w_pos;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = PW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_pos]) begin
        o_any        = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/matrix_result_arbiter.sv
// Shares one result-RAM write port between NCORES compute cores.
// Cores are granted round-robin; the winner is registered onto the write
// port, which holds while wr_ready is low. Accepted writes are counted and
// done pulses once all (sizex+1)*(sizey+1) cells have been written.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : arm a new job (also restarts a running job)
//   sizex, sizey    : last column / row index, inclusive
//   core_valid/rx/ry/data : per-core result, packed slice i per core
//   core_ack        : one-hot, combinational take of core i's result
//   wr_en/addr/data : write request, addr = {ry, rx}
//   wr_ready        : RAM accepts the write this cycle
//   busy, done, err : job armed, last-write pulse, sticky protocol error
module matrix_result_arbiter
  import matrix_pkg::*;
#(
  parameter int maxWidthLen = MAXW_DEF,
  parameter int sizeValue   = 16,
  parameter int NCORES      = NCORES_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [maxWidthLen-1:0]          sizex,
  input  logic [maxWidthLen-1:0]          sizey,
  input  logic [NCORES-1:0]               core_valid,
  input  logic [NCORES*maxWidthLen-1:0]   core_rx,
  input  logic [NCORES*maxWidthLen-1:0]   core_ry,
  input  logic [NCORES*sizeValue-1:0]     core_data,
  output logic [NCORES-1:0]               core_ack,
  output logic                            wr_en,
  output logic [2*maxWidthLen-1:0]        wr_addr,
  output logic [sizeValue-1:0]            wr_data,
  input  logic                            wr_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int AW = 2*maxWidthLen;
  localparam int CW = 2*maxWidthLen + 1;
  localparam int PW = $clog2(NCORES);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          r_expected;
  logic [PW-1:0]          r_ptr;
  logic [maxWidthLen-1:0] r_sizex;
  logic [maxWidthLen-1:0] r_sizey;
  logic                   r_wr_en;
  logic [AW-1:0]          r_wr_addr;
  logic [sizeValue-1:0]   r_wr_data;
  logic                   r_done;
  logic                   r_err;

  logic [NCORES-1:0]      w_gnt;
  logic [PW-1:0]          w_idx;
  logic                   w_any;
  logic                   w_free;
  logic                   w_accept;
  logic                   w_final;
  logic                   w_grant;
  logic                   w_oob;
  logic [maxWidthLen-1:0] w_rx;
  logic [maxWidthLen-1:0] w_ry;
  logic [sizeValue-1:0]   w_data;
  logic [PW-1:0]          w_ptr_nxt;
  logic [CW-1:0]          w_expected;

  rr_picker #(.N(NCORES), .PW(PW)) u_picker (
    .i_req (core_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_rx   = '0;
    w_ry   = '0;
    w_data = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (w_idx == PW'(i)) begin
        w_rx   = core_rx[i*maxWidthLen +: maxWidthLen];
        w_ry   = core_ry[i*maxWidthLen +: maxWidthLen];
        w_data = core_data[i*sizeValue +: sizeValue];
      end
    end
  end

  // Full-width product: (2^W)*(2^W) still fits in CW bits.
  assign w_expected = (CW'(sizex) + CW'(1)) * (CW'(sizey) + CW'(1));
  assign w_free     = !r_wr_en || wr_ready;
  assign w_accept   = r_wr_en && wr_ready;
  assign w_oob      = (w_rx > r_sizex) || (w_ry > r_sizey);
  assign w_ptr_nxt  = (w_idx == PW'(NCORES-1)) ? '0 : w_idx + PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_final     = 1'b0;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_final = w_accept && ((r_count + CW'(1)) == r_expected);
        // start restarts the job and suppresses both grant and completion.
        if (start)        w_state_nxt = ST_RUN;
        else if (w_final) w_state_nxt = ST_IDLE;
        else              w_grant     = w_free && w_any;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_expected <= '0;
      r_ptr      <= '0;
      r_sizex    <= '0;
      r_sizey    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_expected <= w_expected;
        r_sizex    <= sizex;
        r_sizey    <= sizey;
        r_count    <= '0;
        r_ptr      <= '0;
        r_wr_en    <= 1'b0;
        r_err      <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        if (|core_valid) r_err <= 1'b1;
      end else begin
        if (w_accept) r_count <= r_count + CW'(1);
        if (w_final) begin
          r_done  <= 1'b1;
          r_wr_en <= 1'b0;
        end else if (w_grant) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= {w_ry, w_rx};
          r_wr_data <= w_data;
          r_ptr     <= w_ptr_nxt;
          if (w_oob) r_err <= 1'b1;
        end else if (w_free) begin
          r_wr_en <= 1'b0;
        end
      end
    end
  end

  assign core_ack = w_grant ? w_gnt : '0;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_matrix_result_arbiter.sv
module tb_matrix_result_arbiter;

  localparam int MW = 4;
  localparam int SV = 16;
  localparam int NC = 5;

  logic            clk;
  logic            rst;
  logic            start;
  logic [MW-1:0]   sizex;
  logic [MW-1:0]   sizey;
  logic [NC-1:0]   core_valid;
  logic [NC*MW-1:0] core_rx;
  logic [NC*MW-1:0] core_ry;
  logic [NC*SV-1:0] core_data;
  logic [NC-1:0]   core_ack;
  logic            wr_en;
  logic [2*MW-1:0] wr_addr;
  logic [SV-1:0]   wr_data;
  logic            wr_ready;
  logic            busy;
  logic            done;
  logic            err;

  logic [MW-1:0]   crx [NC];
  logic [MW-1:0]   cry [NC];
  logic [SV-1:0]   cdat[NC];

  int n_checks;
  int n_errors;

  matrix_result_arbiter #(.maxWidthLen(MW), .sizeValue(SV), .NCORES(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sizex      (sizex),
    .sizey      (sizey),
    .core_valid (core_valid),
    .core_rx    (core_rx),
    .core_ry    (core_ry),
    .core_data  (core_data),
    .core_ack   (core_ack),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    core_rx   = '0;
    core_ry   = '0;
    core_data = '0;
    for (int i = 0; i < NC; i++) begin
      core_rx[i*MW +: MW]   = crx[i];
      core_ry[i*MW +: MW]   = cry[i];
      core_data[i*SV +: SV] = cdat[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic          st;
    logic [MW-1:0] sx;
    logic [MW-1:0] sy;
    logic [NC-1:0] vld;
    logic          rdy;
    logic [NC-1:0] e_ack;
    logic          e_wen;
    logic [7:0]    e_addr;
    logic [15:0]   e_data;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic [3:0] sx, input logic [3:0] sy,
                              input logic [4:0] vld, input logic rdy, input logic [4:0] e_ack,
                              input logic e_wen, input logic [7:0] e_addr, input logic [15:0] e_data,
                              input logic e_busy, input logic e_done, input logic e_err);
    vec_t v;
    v.st = st; v.sx = sx; v.sy = sy; v.vld = vld; v.rdy = rdy; v.e_ack = e_ack;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_data = e_data;
    v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Core i holds cell (rx=i%2, ry=i/2) with value A000+i.
  task automatic default_cores();
    for (int i = 0; i < NC; i++) begin
      crx[i]  = MW'(i % 2);
      cry[i]  = MW'(i / 2);
      cdat[i] = SV'(16'hA000 + i);
    end
  endtask

  task automatic drive(input logic st, input logic [3:0] sx, input logic [3:0] sy,
                       input logic [4:0] vld, input logic rdy);
    start = st; sizex = sx; sizey = sy; core_valid = vld; wr_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    default_cores();
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 5'b0, 1'b1);
    #12;
    chk("reset.wr_en", 32'(wr_en), 32'd0);
    chk("reset.busy",  32'(busy),  32'd0);
    chk("reset.done",  32'(done),  32'd0);
    chk("reset.err",   32'(err),   32'd0);
    chk("reset.addr",  32'(wr_addr), 32'd0);
    chk("reset.data",  32'(wr_data), 32'd0);
    chk("reset.ack",   32'(core_ack), 32'd0);
    rst = 1'b1;
    tick();

    // Fairness: 2x3 job, all cores valid, RAM always ready.
    tbl.push_back(mk(1, 1, 2, 5'b00000, 1, 5'b00000, 0, 8'h00, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b11111, 1, 5'b00001, 1, 8'h00, 16'hA000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b11111, 1, 5'b00010, 1, 8'h01, 16'hA001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b11111, 1, 5'b00100, 1, 8'h10, 16'hA002, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b11111, 1, 5'b01000, 1, 8'h11, 16'hA003, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b11111, 1, 5'b10000, 1, 8'h20, 16'hA004, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b11111, 1, 5'b00001, 1, 8'h00, 16'hA000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b11111, 1, 5'b00000, 0, 8'h00, 16'hA000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 2, 5'b00000, 1, 5'b00000, 0, 8'h00, 16'hA000, 0, 0, 0));
    // Backpressure: cores 1 and 3, RAM stalled for four cycles.
    tbl.push_back(mk(1, 1, 2, 5'b00000, 1, 5'b00000, 0, 8'h00, 16'hA000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b01010, 0, 5'b00010, 1, 8'h01, 16'hA001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b01010, 0, 5'b00000, 1, 8'h01, 16'hA001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b01010, 0, 5'b00000, 1, 8'h01, 16'hA001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b01010, 0, 5'b00000, 1, 8'h01, 16'hA001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b01010, 0, 5'b00000, 1, 8'h01, 16'hA001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b01010, 1, 5'b01000, 1, 8'h11, 16'hA003, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2, 5'b01010, 1, 5'b00010, 1, 8'h01, 16'hA001, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].sx, tbl[i].sy, tbl[i].vld, tbl[i].rdy);
      #1;
      chk($sformatf("row%0d.ack", i), 32'(core_ack), 32'(tbl[i].e_ack));
      tick();
      chk($sformatf("row%0d.wr_en", i), 32'(wr_en),   32'(tbl[i].e_wen));
      chk($sformatf("row%0d.addr", i),  32'(wr_addr), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d.data", i),  32'(wr_data), 32'(tbl[i].e_data));
      chk($sformatf("row%0d.busy", i),  32'(busy),    32'(tbl[i].e_busy));
      chk($sformatf("row%0d.done", i),  32'(done),    32'(tbl[i].e_done));
      chk($sformatf("row%0d.err", i),   32'(err),     32'(tbl[i].e_err));
    end

    // 1x1 job served by core 2.
    crx[2] = 4'd0; cry[2] = 4'd0; cdat[2] = 16'h1234;
    drive(1'b1, 4'd0, 4'd0, 5'b00000, 1'b1);
    tick();
    chk("one.busy", 32'(busy), 32'd1);
    chk("one.wr_en_idle", 32'(wr_en), 32'd0);
    drive(1'b0, 4'd0, 4'd0, 5'b00100, 1'b1);
    #1;
    chk("one.ack", 32'(core_ack), 32'b00100);
    tick();
    chk("one.wr_en", 32'(wr_en), 32'd1);
    chk("one.addr", 32'(wr_addr), 32'h00);
    chk("one.data", 32'(wr_data), 32'h1234);
    drive(1'b0, 4'd0, 4'd0, 5'b00000, 1'b1);
    tick();
    chk("one.done", 32'(done), 32'd1);
    chk("one.busy_fall", 32'(busy), 32'd0);
    chk("one.wr_en_fall", 32'(wr_en), 32'd0);
    tick();
    chk("one.done_pulse", 32'(done), 32'd0);
    default_cores();

    // Restart after 3 of 9 writes; 9 fresh acceptances needed.
    drive(1'b1, 4'd2, 4'd2, 5'b00000, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'd2, 4'd2, 5'b11111, 1'b1);
      tick();
    end
    drive(1'b1, 4'd2, 4'd2, 5'b11111, 1'b1);
    #1;
    chk("restart.ack_in_start", 32'(core_ack), 32'd0);
    tick();
    chk("restart.wr_en", 32'(wr_en), 32'd0);
    chk("restart.busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 4'd2, 4'd2, 5'b11111, 1'b1);
      #1;
      chk($sformatf("restart.ack%0d", k), 32'(core_ack),
          (k <= 9) ? (32'd1 << ((k - 1) % NC)) : 32'd0);
      tick();
      chk($sformatf("restart.done%0d", k), 32'(done), (k == 10) ? 32'd1 : 32'd0);
    end
    chk("restart.busy_end", 32'(busy), 32'd0);

    // Error flag: valid while idle, then an out-of-range coordinate.
    drive(1'b0, 4'd2, 4'd2, 5'b00001, 1'b1);
    tick();
    chk("err.idle_valid", 32'(err), 32'd1);
    drive(1'b0, 4'd2, 4'd2, 5'b00000, 1'b1);
    tick();
    tick();
    chk("err.sticky", 32'(err), 32'd1);
    drive(1'b1, 4'd1, 4'd1, 5'b00000, 1'b1);
    tick();
    chk("err.cleared", 32'(err), 32'd0);
    crx[0] = 4'd3;
    drive(1'b0, 4'd1, 4'd1, 5'b00001, 1'b1);
    #1;
    chk("err.oob_ack", 32'(core_ack), 32'b00001);
    tick();
    chk("err.oob_set", 32'(err), 32'd1);
    chk("err.oob_wr_en", 32'(wr_en), 32'd1);
    chk("err.oob_addr", 32'(wr_addr), 32'h03);
    drive(1'b0, 4'd1, 4'd1, 5'b00000, 1'b1);
    tick();
    chk("err.oob_hold", 32'(err), 32'd1);
    default_cores();
    drive(1'b1, 4'd1, 4'd1, 5'b00000, 1'b1);
    tick();
    chk("err.start_clear", 32'(err), 32'd0);

    // Asynchronous reset in the middle of a job.
    drive(1'b0, 4'd1, 4'd1, 5'b11111, 1'b1);
    tick();
    chk("arst.pre_wr_en", 32'(wr_en), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst.wr_en", 32'(wr_en), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.ack", 32'(core_ack), 32'd0);
    chk("arst.addr", 32'(wr_addr), 32'd0);
    tick();
    chk("arst.done_low", 32'(done), 32'd0);
    drive(1'b0, 4'd1, 4'd1, 5'b00000, 1'b1);
    rst = 1'b1;
    tick();
    chk("arst.done_after", 32'(done), 32'd0);
    chk("arst.busy_after", 32'(busy), 32'd0);
    chk("arst.err_after", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matrix_result_arbiter.md
Name: matrix_result_arbiter

Overview:
Shares one result-memory write port between the NCORES matrix compute cores that the cell dispatcher starts. Each core presents a finished cell result (rx, ry, value). The block grants cores round-robin, registers the winner onto a single write port with backpressure, and counts accepted writes. It raises done when all (sizex+1)*(sizey+1) cells have been written. It sits between the core array and the result RAM, alongside the dispatcher.

Parameters:
maxWidthLen, 4, coordinate width; matrix side up to 2^maxWidthLen
sizeValue, 16, width of one result cell
NCORES, 5, number of requesting cores (legal 2..8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  one-cycle pulse: arm a new job, latch sizex/sizey
sizex  in  maxWidthLen  last column index (inclusive)
sizey  in  maxWidthLen  last row index (inclusive)
core_valid  in  NCORES  core i holds a result
core_rx  in  NCORES*maxWidthLen  column of core i, slice i
core_ry  in  NCORES*maxWidthLen  row of core i, slice i
core_data  in  NCORES*sizeValue  result of core i, slice i
core_ack  out  NCORES  one-hot, combinational; result of core i taken this cycle
wr_en  out  1  write request to result RAM
wr_addr  out  2*maxWidthLen  {ry, rx}
wr_data  out  sizeValue  result value
wr_ready  in  1  RAM accepts write this cycle
busy  out  1  job armed
done  out  1  one-cycle pulse: last write accepted
err  out  1  sticky protocol error; cleared by start

Behaviour:
- Reset (rst=0, async): state IDLE; wr_en, busy, done, err = 0; wr_addr, wr_data = 0; count = 0; ptr = 0; core_ack = 0.
- States: IDLE, RUN. done is a registered pulse, not a state.
- IDLE: core_ack = 0. Any core_valid=1 sets err. On start: expected = (sizex+1)*(sizey+1), computed at 2*maxWidthLen+1 bits with no overflow. Also count = 0, ptr = 0, next state RUN.
- RUN, output stage "free" = (wr_en==0) or (wr_en & wr_ready).
- Grant: when free and any core_valid, pick the first valid core at or after ptr, wrapping modulo NCORES. Assert core_ack[g] the same cycle.
- At the edge after a grant: wr_en=1, wr_addr={core_ry[g],core_rx[g]}, wr_data=core_data[g], ptr=(g+1) mod NCORES.
- No grant while not free. Cores hold valid/rx/ry/data stable until ack. wr_en/addr/data stay stable while wr_ready=0.
- Free with no grant: wr_en drops to 0 at the next edge.
- Latency: valid to ack is 0 cycles. Ack to wr_en is 1 cycle. Sustained throughput is 1 write/cycle with wr_ready=1.
- A write is accepted on wr_en & wr_ready, and count increments.
- On the acceptance that makes count==expected: done=1 the next cycle, state IDLE, busy=0, wr_en=0. No grant is issued in that cycle.
- A granted coordinate outside sizex/sizey sets err. The write still proceeds.
- start during RUN: restart as above, with new expected, count=0 and ptr=0. The pending wr_en is dropped at the next edge. No ack is issued in the start cycle.
- start in the same cycle as the final acceptance: start wins, and done is not pulsed.
- busy = (state==RUN).
- rst asserted mid-job: everything returns to its reset values immediately. No done is produced.

Decomposition:
- Shared package matrix_pkg:
  - state encoding (ST_IDLE, ST_RUN)
  - NCORES default
  - ADDR_W = 2*maxWidthLen and CNT_W = 2*maxWidthLen+1 constants
- Sub-module: rr_picker, combinational. Inputs are the request vector and ptr; outputs are the one-hot grant plus its index and an any-flag.

Test Plan:
- 1x1 job: sizex=0, sizey=0; core 2 valid (rx=0, ry=0, data=0x1234) -> ack[2] same cycle; wr_en next cycle with addr=0, data=0x1234; done pulse one cycle after acceptance; busy falls.
- Fairness: 2x3 job (sizex=1, sizey=2, expected 6); all 5 cores valid, wr_ready=1 -> acks in order 0,1,2,3,4 on consecutive cycles, then core 0 again for the 6th cell; done after the 6th acceptance; count=6.
- Backpressure: wr_ready=0 for 4 cycles with cores 1 and 3 valid -> wr_en/addr/data frozen; no further ack; on wr_ready=1, the next ack goes to core 3.
- Restart: start again after 3 of 9 writes (sizex=2, sizey=2) -> wr_en low next cycle; no ack in the start cycle; 9 new acceptances are required before done.
- Errors: core_valid in IDLE -> err=1 and stays set; a granted rx=3 with sizex=1 -> err=1 and the write still issued; next start clears err.
- Async reset mid-run: drop rst between clock edges -> wr_en, busy and core_ack go to 0 immediately; no done pulse.
